parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_pkg.sv | 15 +
 rtl/gate_timer.sv | 29 ++
 rtl/parking_gate_ctrl.sv | 126 ++++++++++++
 tb/tb_parking_gate_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate controller.
// Holds the gate FSM state enum and the default capacity/open-time values.
package parking_pkg;

  localparam int CAPACITY_DEF    = 25;
  localparam int OPEN_CYCLES_DEF = 4;
  localparam int TMR_W           = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } gate_state_e;

endpackage

// File: rtl/gate_timer.sv
// Gate-open down-counter; loads load_val, counts to zero, then holds.
// Ports: Clk, Rst (async high), load, load_val, done (timer == 0).
module gate_timer
  import parking_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] tmr_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      tmr_q <= '0;
    end else if (load) begin
      tmr_q <= load_val;
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - W'(1);
    end
  end

  assign done = (tmr_q == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-lane parking gate: latches entry/exit requests, arbitrates
// round-robin, tracks occupancy and drives the gate for OPEN_CYCLES.
// Ports: Clk, Rst (async high), enter_req/exit_req pulses in;
// gate_open, grant_enter/exit, count, full, empty, overrun out.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = CAPACITY_DEF,
  parameter int OPEN_CYCLES = OPEN_CYCLES_DEF,
  parameter int CNT_W       = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             enter_req,
  input  logic             exit_req,
  output logic             gate_open,
  output logic             grant_enter,
  output logic             grant_exit,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] LOAD_C = TMR_W'(OPEN_CYCLES - 1);

  gate_state_e      state_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_in_q, pend_in_d;
  logic             pend_out_q, pend_out_d;
  logic             last_exit_q;
  logic             gate_q, gnt_in_q, gnt_out_q, ovr_q;

  logic in_ok, out_ok, idle;
  logic do_in, do_out, drop_out;
  logic ovr_hit, tmr_done;

  assign idle   = (state_q == IDLE);
  assign in_ok  = pend_in_q && (count_q < CAP_C);
  assign out_ok = pend_out_q && (count_q != '0);

  // Round-robin: with both eligible, serve the type not served last.
  assign do_in  = idle && in_ok && (!out_ok || last_exit_q);
  assign do_out = idle && out_ok && (!in_ok || !last_exit_q);

  // An exit seen with the lot empty is dropped, not held.
  assign drop_out = pend_out_q && (count_q == '0);

  assign pend_in_d  = (pend_in_q & ~do_in) | enter_req;
  assign pend_out_d = (pend_out_q & ~(do_out | drop_out)) | exit_req;

  assign ovr_hit = (enter_req & pend_in_q & ~do_in)
                 | (exit_req & pend_out_q & ~(do_out | drop_out));

  always_comb begin
    count_d = count_q;
    if (do_in) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_out) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  gate_timer #(.W(TMR_W)) u_tmr (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (do_in | do_out),
    .load_val (LOAD_C),
    .done     (tmr_done)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pend_in_q   <= 1'b0;
      pend_out_q  <= 1'b0;
      last_exit_q <= 1'b1;
      gate_q      <= 1'b0;
      gnt_in_q    <= 1'b0;
      gnt_out_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      count_q    <= count_d;
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
      gnt_in_q   <= do_in;
      gnt_out_q  <= do_out;
      if (ovr_hit) begin
        ovr_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (do_in || do_out) begin
            state_q     <= OPEN;
            gate_q      <= 1'b1;
            last_exit_q <= do_out;
          end
        end
        OPEN: begin
          if (tmr_done) begin
            state_q <= CLOSE;
            gate_q  <= 1'b0;
          end
        end
        CLOSE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gate_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gate_open   = gate_q;
  assign grant_enter = gnt_in_q;
  assign grant_exit  = gnt_out_q;
  assign count       = count_q;
  assign full        = (count_q == CAP_C);
  assign empty       = (count_q == '0);
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with CAPACITY=3, OPEN_CYCLES=4.
// Inputs change 1ns after a rising edge; outputs sampled there too.
module tb_parking_gate_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       enter_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       gate_open, grant_enter, grant_exit;
  logic [1:0] count;
  logic       full, empty, overrun;

  int checks = 0;
  int failures = 0;

  parking_gate_ctrl #(
    .CAPACITY(3), .OPEN_CYCLES(4), .CNT_W(2)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .enter_req(enter_req), .exit_req(exit_req),
    .gate_open(gate_open),
    .grant_enter(grant_enter), .grant_exit(grant_exit),
    .count(count), .full(full), .empty(empty),
    .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    enter_req = 1'b0;
    exit_req = 1'b0;
    repeat (2) tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic pulse(input logic e, input logic x);
    enter_req = e;
    exit_req = x;
    tick();
    enter_req = 1'b0;
    exit_req = 1'b0;
  endtask

  // Cycles until the chosen grant is seen; -1 if budget runs out.
  task automatic wait_grant(input bit is_x, input int max,
                            output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if ((is_x ? grant_exit : grant_enter) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Sample-then-tick for n cycles, totalling each output's high cycles.
  task automatic run(input int n, output int gi, output int gx,
                     output int go);
    gi = 0; gx = 0; go = 0;
    for (int i = 0; i < n; i++) begin
      gi += int'(grant_enter);
      gx += int'(grant_exit);
      go += int'(gate_open);
      tick();
    end
  endtask

  int n, gi, gx, go;

  initial begin
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_gate", gate_open, 0);
    chk("rst_gnt", grant_enter | grant_exit, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovr", overrun, 0);

    // Single enter
    pulse(1, 0);
    chk("a_nogrant_yet", grant_enter, 0);
    wait_grant(0, 4, n);
    chk("a_lat", n, 1);
    chk("a_count", count, 1);
    chk("a_gate_on", gate_open, 1);
    run(8, gi, gx, go);
    chk("a_gate_cyc", go, 4);
    chk("a_gnt_cyc", gi, 1);
    chk("a_gate_off", gate_open, 0);

    // Set last served to exit at count 1, then both together
    pulse(1, 0);
    wait_grant(0, 4, n);
    chk("b_pre_cnt2", count, 2);
    run(7, gi, gx, go);
    pulse(0, 1);
    wait_grant(1, 4, n);
    chk("b_pre_cnt1", count, 1);
    run(7, gi, gx, go);
    pulse(1, 1);
    wait_grant(0, 4, n);
    chk("b_enter_first", n, 1);
    chk("b_cnt_up", count, 2);
    chk("b_no_exit_yet", grant_exit, 0);
    wait_grant(1, 10, n);
    chk("b_exit_gap", n, 6);
    chk("b_cnt_down", count, 1);
    run(7, gi, gx, go);

    // Fill to capacity, fourth enter held
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(1, 0);
      wait_grant(0, 4, n);
      chk("c_fill_lat", n, 1);
      run(7, gi, gx, go);
    end
    chk("c_count3", count, 3);
    chk("c_full", full, 1);
    pulse(1, 0);
    wait_grant(0, 8, n);
    chk("c_held", n, -1);
    chk("c_held_cnt", count, 3);
    pulse(0, 1);
    wait_grant(1, 4, n);
    chk("c_exit_lat", n, 1);
    chk("c_exit_cnt", count, 2);
    chk("c_not_full", full, 0);
    wait_grant(0, 10, n);
    chk("c_held_served", n, 6);
    chk("c_refill", count, 3);
    run(7, gi, gx, go);

    // Exit while empty is dropped
    do_reset();
    pulse(0, 1);
    run(8, gi, gx, go);
    chk("d_gnts", gi + gx, 0);
    chk("d_gate", go, 0);
    chk("d_count", count, 0);
    pulse(1, 0);
    wait_grant(0, 4, n);
    chk("d_enter", n, 1);
    wait_grant(1, 10, n);
    chk("d_exit_gone", n, -1);
    chk("d_ovr", overrun, 0);

    // Two enters inside one OPEN window
    do_reset();
    pulse(1, 0);
    wait_grant(0, 4, n);
    pulse(1, 0);
    chk("e_ovr_first", overrun, 0);
    pulse(1, 0);
    chk("e_ovr", overrun, 1);
    run(20, gi, gx, go);
    chk("e_extra_gnt", gi, 1);
    chk("e_count", count, 2);

    // Reset during the second OPEN cycle
    do_reset();
    pulse(1, 0);
    wait_grant(0, 4, n);
    pulse(1, 0);
    chk("f_gate_pre", gate_open, 1);
    Rst = 1'b1;
    #1;
    chk("f_gate_rst", gate_open, 0);
    chk("f_count_rst", count, 0);
    tick();
    Rst = 1'b0;
    tick();
    run(12, gi, gx, go);
    chk("f_no_gnt", gi + gx, 0);
    chk("f_no_gate", go, 0);
    pulse(1, 0);
    wait_grant(0, 4, n);
    chk("f_new_req", n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
